// File: rtl/feature_read_align_pkg.sv
// Shared NPU definitions for the feature read/align stage.
// Holds parallel-mode codes, bus width defaults, FSM encoding and the sideband bundle.
package feature_read_align_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 128;

    localparam logic [1:0] PARA_MODE_CONV = 2'd0;
    localparam logic [1:0] PARA_MODE_POOL = 2'd1;
    localparam logic [1:0] PARA_MODE_SORT = 2'd2;
    localparam logic [1:0] PARA_MODE_FC   = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    typedef struct packed {
        logic beat;
        logic pad;
        logic feature_end;
        logic pooling_out;
        logic sort_out;
    } sb_t;

    localparam int SB_W = $bits(sb_t);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/feature_sideband_delay.sv
// RD_LAT-deep shift of the sideband bundle, running alongside the SRAM read.
// any_vld flags entries that will still be in flight after this cycle.
module feature_sideband_delay
    import feature_read_align_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  sb_t  din,
    output sb_t  dout,
    output logic any_vld
);

    sb_t [RD_LAT-1:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[RD_LAT-1];

    // The tail entry is leaving this cycle, so it does not hold off drain.
    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            any_vld = any_vld | (|pipe[i]);
        end
    end

endmodule

// File: rtl/feature_read_align.sv
// Issues IO-buffer reads, substitutes pad words and realigns sideband pulses.
// Optional FEAT_READ_PERF_CNT_EN adds saturating read / pad counters.
module feature_read_align
    import feature_read_align_pkg::*;
#(
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter int         DATA_W  = DATA_W_DEF,
    parameter int         RD_LAT  = 2,
    parameter logic [7:0] PAD_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_calculate,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_rd_en,
    input  logic              i_pad_en,
    input  logic              i_feature_end,
    input  logic              i_pooling_out,
    input  logic              i_sort_out,
    output logic [ADDR_W-1:0] o_buf_rd_addr,
    output logic              o_buf_rd_en,
    input  logic [DATA_W-1:0] i_buf_rd_data,
    output logic [DATA_W-1:0] o_feat_data,
    output logic              o_feat_valid,
    output logic              o_feature_end,
    output logic              o_pooling_out,
    output logic              o_sort_out,
    output logic              o_done,
    output logic              o_proto_err
`ifdef FEAT_READ_PERF_CNT_EN
    ,
    output logic [15:0]       o_rd_cnt,
    output logic [15:0]       o_pad_cnt
`endif
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("feature_read_align: RD_LAT must be 1..4");
    end

    localparam logic [DATA_W-1:0] PAD_WORD = {(DATA_W/8){PAD_VAL}};

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       end_carry;
    logic       rd_req;
    logic       beat_in;
    logic       start_ok;
    logic       dly_busy;
    logic       pending;
    logic       drain_done;
    sb_t        s0_nxt;
    sb_t        s0_sb;
    sb_t        dly_sb;

    assign rd_req   = i_rd_en & ~i_pad_en;
    assign beat_in  = i_rd_en | i_pad_en;
    assign start_ok = start_calculate & (state == ST_IDLE);

    always_comb begin
        s0_nxt             = '0;
        s0_nxt.beat        = beat_in;
        s0_nxt.pad         = i_pad_en;
        s0_nxt.feature_end = i_feature_end;
        s0_nxt.pooling_out = i_pooling_out;
        s0_nxt.sort_out    = i_sort_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_sb         <= '0;
            o_buf_rd_en   <= 1'b0;
            o_buf_rd_addr <= '0;
        end else begin
            s0_sb       <= s0_nxt;
            o_buf_rd_en <= rd_req;
            if (rd_req) begin
                o_buf_rd_addr <= i_rd_addr;
            end
        end
    end

    feature_sideband_delay #(
        .RD_LAT (RD_LAT)
    ) u_sb_delay (
        .clk     (clk),
        .rst     (rst),
        .din     (s0_sb),
        .dout    (dly_sb),
        .any_vld (dly_busy)
    );

    // A job finishes once nothing but the outgoing tail entry is in flight.
    assign pending = beat_in | i_feature_end | i_pooling_out | i_sort_out
                   | (|s0_sb) | dly_busy;
    assign drain_done = (state == ST_DRAIN) & ~pending;

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == ST_IDLE): begin
                if (start_calculate) state_nxt = ST_ACTIVE;
            end
            (state == ST_ACTIVE): begin
                if (i_feature_end | end_carry) state_nxt = ST_DRAIN;
            end
            (state == ST_DRAIN): begin
                if (drain_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            end_carry <= 1'b0;
        end else begin
            state     <= state_nxt;
            end_carry <= start_ok & i_feature_end;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_proto_err <= 1'b0;
        end else if (start_ok) begin
            o_proto_err <= 1'b0;
        end else if (start_calculate | (beat_in & (state == ST_IDLE))) begin
            o_proto_err <= 1'b1;
        end
    end

    always_comb begin
        o_feat_data = '0;
        if (dly_sb.beat) begin
            o_feat_data = dly_sb.pad ? PAD_WORD : i_buf_rd_data;
        end
    end

    assign o_feat_valid  = dly_sb.beat;
    assign o_feature_end = dly_sb.feature_end;
    assign o_pooling_out = dly_sb.pooling_out;
    assign o_sort_out    = dly_sb.sort_out;
    assign o_done        = drain_done;

`ifdef FEAT_READ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_cnt  <= '0;
            o_pad_cnt <= '0;
        end else if (start_ok) begin
            o_rd_cnt  <= '0;
            o_pad_cnt <= '0;
        end else begin
            if (o_buf_rd_en) begin
                o_rd_cnt <= sat_inc(o_rd_cnt);
            end
            if (dly_sb.beat & dly_sb.pad) begin
                o_pad_cnt <= sat_inc(o_pad_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_feature_read_align.sv
// Bench for feature_read_align: three builds (RD_LAT 1, 2, 4) share one stimulus.
// A cycle-indexed input history predicts every output; literal checks pin the model.
module tb_feature_read_align;

    localparam int AW = 13;
    localparam int DW = 128;
    localparam int NG = 3;
    localparam int HN = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_calculate;
    logic [AW-1:0] i_rd_addr;
    logic          i_rd_en;
    logic          i_pad_en;
    logic          i_fe;
    logic          i_po;
    logic          i_so;

    logic [NG-1:0] fv, fe_o, po_o, so_o, dn_o, er_o, bre;
    logic [DW-1:0] fd  [NG];
    logic [AW-1:0] bra [NG];

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    for (genvar g = 0; g < NG; g++) begin : gi
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [AW-1:0] ba;
        logic          be, v, fe, po, so, dn, er;
        logic [DW-1:0] rd, fdat;
        logic [DW-1:0] mp [L];

        feature_read_align #(.RD_LAT(L)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .start_calculate (start_calculate),
            .i_rd_addr       (i_rd_addr),
            .i_rd_en         (i_rd_en),
            .i_pad_en        (i_pad_en),
            .i_feature_end   (i_fe),
            .i_pooling_out   (i_po),
            .i_sort_out      (i_so),
            .o_buf_rd_addr   (ba),
            .o_buf_rd_en     (be),
            .i_buf_rd_data   (rd),
            .o_feat_data     (fdat),
            .o_feat_valid    (v),
            .o_feature_end   (fe),
            .o_pooling_out   (po),
            .o_sort_out      (so),
            .o_done          (dn),
            .o_proto_err     (er)
        );

        // SRAM model: returns the address as data, garbage when not read.
        always @(posedge clk) begin
            mp[0] <= be ? DW'(ba) : {4{32'hDEADBEEF}};
            for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
        end
        assign rd = mp[L-1];

        assign fv[g]   = v;
        assign fd[g]   = fdat;
        assign fe_o[g] = fe;
        assign po_o[g] = po;
        assign so_o[g] = so;
        assign dn_o[g] = dn;
        assign er_o[g] = er;
        assign bre[g]  = be;
        assign bra[g]  = ba;
    end

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic          h_rd [HN];
    logic          h_pad[HN];
    logic          h_fe [HN];
    logic          h_po [HN];
    logic          h_so [HN];
    logic [AW-1:0] h_adr[HN];
    int            cyc      = 0;
    int            last_rst = -1;

    logic          m_act [NG];
    int            m_dend[NG];
    logic          m_err [NG];

    logic [NG-1:0] lg_fv[HN], lg_fe[HN], lg_po[HN], lg_dn[HN], lg_er[HN], lg_be[HN];
    logic [DW-1:0] lg_fd[HN];

    always @(negedge clk) begin : cmp
        int s, s1, L;
        logic ev, efe, epo, eso, eb, busy, istart;
        logic [DW-1:0] ed;
        string tag;
        if (cyc < HN) begin
            h_rd[cyc]  = i_rd_en;
            h_pad[cyc] = i_pad_en;
            h_fe[cyc]  = i_fe;
            h_po[cyc]  = i_po;
            h_so[cyc]  = i_so;
            h_adr[cyc] = i_rd_addr;
            if (rst) begin
                last_rst = cyc;
                for (int g = 0; g < NG; g++) begin
                    m_act[g]  = 1'b0;
                    m_dend[g] = -1;
                    m_err[g]  = 1'b0;
                end
            end
            for (int g = 0; g < NG; g++) begin
                L  = lat_of(g);
                s  = cyc - 1 - L;
                s1 = cyc - 1;
                tag = $sformatf("c%0d g%0d", cyc, g);
                ev = 0; efe = 0; epo = 0; eso = 0; ed = '0;
                if (s >= 0 && s > last_rst) begin
                    ev  = h_rd[s] | h_pad[s];
                    efe = h_fe[s];
                    epo = h_po[s];
                    eso = h_so[s];
                    if (ev && !h_pad[s]) ed = DW'(h_adr[s]);
                end
                chk({tag, " valid"}, DW'(fv[g]), DW'(ev));
                chk({tag, " data"}, fd[g], ed);
                chk({tag, " fe"}, DW'(fe_o[g]), DW'(efe));
                chk({tag, " pool"}, DW'(po_o[g]), DW'(epo));
                chk({tag, " sort"}, DW'(so_o[g]), DW'(eso));
                eb = (s1 >= 0 && s1 > last_rst) ? (h_rd[s1] & ~h_pad[s1]) : 1'b0;
                chk({tag, " rd_en"}, DW'(bre[g]), DW'(eb));
                if (eb) chk({tag, " rd_addr"}, DW'(bra[g]), DW'(h_adr[s1]));
                chk({tag, " done"}, DW'(dn_o[g]), DW'(!rst && cyc == m_dend[g]));
                chk({tag, " err"}, DW'(er_o[g]), DW'(m_err[g]));
            end
            lg_fv[cyc] = fv;
            lg_fe[cyc] = fe_o;
            lg_po[cyc] = po_o;
            lg_dn[cyc] = dn_o;
            lg_er[cyc] = er_o;
            lg_be[cyc] = bre;
            lg_fd[cyc] = fd[1];
            if (!rst) begin
                for (int g = 0; g < NG; g++) begin
                    busy   = m_act[g] || (cyc <= m_dend[g]);
                    istart = start_calculate && !busy;
                    if (start_calculate) m_err[g] = busy;
                    else if ((i_rd_en | i_pad_en) && !busy) m_err[g] = 1'b1;
                    if (i_fe && (m_act[g] || istart)) begin
                        m_act[g]  = 1'b0;
                        m_dend[g] = cyc + 1 + lat_of(g);
                    end else if (istart) begin
                        m_act[g] = 1'b1;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic drive(input logic st, input logic rd, input logic pad,
                         input logic [AW-1:0] a, input logic fe,
                         input logic po, input logic so);
        start_calculate = st;
        i_rd_en   = rd;
        i_pad_en  = pad;
        i_rd_addr = a;
        i_fe      = fe;
        i_po      = po;
        i_so      = so;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, '0, 0, 0, 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int c0, cp, cs, cf, ci, ce1, ce2, cx, cr, crs, nd;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        drive(1, 0, 0, '0, 0, 0, 0);
        c0 = cyc;
        for (int k = 0; k < 4; k++) drive(0, 1, 0, AW'(16 + k), 0, 0, 0);
        idle(6);

        cp = cyc;
        drive(0, 1, 1, 13'h020, 0, 0, 0);
        idle(6);

        cs = cyc;
        drive(0, 0, 0, '0, 0, 1, 0);
        drive(0, 0, 0, '0, 0, 0, 1);
        idle(6);

        cf = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) cf = cyc;
            drive(0, 1, 0, AW'(256 + k), k == 7, 0, 0);
        end
        idle(8);

        ci = cyc;
        drive(0, 1, 0, 13'h030, 0, 0, 0);
        idle(4);
        ce1 = cyc;
        drive(1, 0, 0, '0, 0, 0, 0);
        ce2 = cyc;
        drive(1, 0, 0, '0, 0, 0, 0);
        idle(2);
        cx = cyc;
        drive(0, 0, 0, '0, 1, 0, 0);
        idle(8);

        cr = cyc;
        drive(1, 1, 0, 13'h040, 1, 0, 0);
        idle(8);

        drive(1, 0, 0, '0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, AW'(80 + k), 0, 0, 0);
        crs = cyc;
        start_calculate = 0; i_rd_en = 0; i_pad_en = 0;
        i_fe = 0; i_po = 0; i_so = 0;
        rst = 1'b1;
        #1;
        chk("async rst valid", DW'(fv), '0);
        chk("async rst rd_en", DW'(bre), '0);
        chk("async rst data", fd[0], '0);
        chk("async rst done", DW'(dn_o), '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);

        chk("reset err", DW'(lg_er[1]), '0);
        chk("reset valid", DW'(lg_fv[1]), '0);
        chk("read rd_en +1", DW'(lg_be[c0 + 1][1]), 1);
        chk("read early", DW'(lg_fv[c0 + 2][1]), 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("read valid %0d", k), DW'(lg_fv[c0 + 3 + k][1]), 1);
            chk($sformatf("read data %0d", k), lg_fd[c0 + 3 + k], DW'(16 + k));
        end
        chk("read lat1", DW'(lg_fv[c0 + 2][0]), 1);
        chk("read lat4 early", DW'(lg_fv[c0 + 4][2]), 0);
        chk("read lat4", DW'(lg_fv[c0 + 5][2]), 1);
        chk("pad rd_en", DW'(lg_be[cp + 1][1]), 0);
        chk("pad valid", DW'(lg_fv[cp + 3][1]), 1);
        chk("pad data", lg_fd[cp + 3], 128'h0);
        chk("pool pulse", DW'(lg_po[cs + 3][1]), 1);
        chk("pool no valid", DW'(lg_fv[cs + 3][1]), 0);
        chk("pool lat1", DW'(lg_po[cs + 2][0]), 1);
        chk("pool lat4", DW'(lg_po[cs + 5][2]), 1);
        chk("drain fe", DW'(lg_fe[cf + 3][1]), 1);
        chk("drain valid", DW'(lg_fv[cf + 3][1]), 1);
        chk("drain done", DW'(lg_dn[cf + 3][1]), 1);
        chk("drain done lat1", DW'(lg_dn[cf + 2][0]), 1);
        chk("drain done lat4", DW'(lg_dn[cf + 5][2]), 1);
        nd = 0;
        for (int k = cf - 8; k <= cf + 8; k++) nd += int'(lg_dn[k][1]);
        chk("drain done once", DW'(nd), 1);
        chk("idle beat err", DW'(lg_er[ci + 1][1]), 1);
        chk("idle start clr", DW'(lg_er[ce1 + 1][1]), 0);
        chk("restart err", DW'(lg_er[ce2 + 1][1]), 1);
        chk("err sticky", DW'(lg_er[cx + 6][1]), 1);
        chk("err job done", DW'(lg_dn[cx + 3][1]), 1);
        chk("start+end clr", DW'(lg_er[cr + 1][1]), 0);
        chk("start+end done", DW'(lg_dn[cr + 3][1]), 1);
        chk("start+end fe", DW'(lg_fe[cr + 3][1]), 1);
        chk("start+end data", lg_fd[cr + 3], 128'h40);
        chk("start+end lat4", DW'(lg_dn[cr + 5][2]), 1);
        nd = 0;
        for (int k = crs; k <= crs + 11; k++) nd += int'(lg_dn[k][0]) + int'(lg_dn[k][1]) + int'(lg_dn[k][2]);
        chk("rst no done", DW'(nd), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/feature_read_align.md
Name: feature_read_align

Overview:
- Stage directly downstream of the input address generator.
- Takes its per-cycle read address, read enable, pad enable and sideband pulses (feature end, pooling out, sort out), and issues the real IO-buffer SRAM read.
- Replaces padded positions with the pad value and realigns all sideband pulses with returned data.
- Presents a single valid-qualified feature stream to the NPE/WAGU side and reports job completion.

Parameters:
- ADDR_W, 13, IO-buffer address width.
- DATA_W, 128, feature word width (16 lanes x 8 bit).
- RD_LAT, 2, SRAM read latency in cycles from o_buf_rd_en to i_buf_rd_data; legal 1..4.
- PAD_VAL, 0, byte value replicated across DATA_W for padded positions.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start_calculate  in  1  job start pulse from schedule
- i_rd_addr  in  ADDR_W  read address from address generator
- i_rd_en  in  1  read request
- i_pad_en  in  1  padded position (no SRAM read)
- i_feature_end  in  1  last beat of feature tile
- i_pooling_out  in  1  pooling window complete
- i_sort_out  in  1  sort beat marker
- o_buf_rd_addr  out  ADDR_W  SRAM address
- o_buf_rd_en  out  1  SRAM read enable
- i_buf_rd_data  in  DATA_W  SRAM read data
- o_feat_data  out  DATA_W  aligned feature word
- o_feat_valid  out  1  o_feat_data valid
- o_feature_end  out  1  aligned feature end
- o_pooling_out  out  1  aligned pooling marker
- o_sort_out  out  1  aligned sort marker
- o_done  out  1  one-cycle pulse when job fully drained
- o_proto_err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0, state IDLE, pipeline valid bits cleared. Reset mid-job discards in-flight beats; no o_done.
- Stage 0 (registered input):
  - beat = i_rd_en | i_pad_en.
  - o_buf_rd_en = i_rd_en & ~i_pad_en, one cycle after the input.
  - o_buf_rd_addr = i_rd_addr registered; holds its last value when not reading.
  - i_pad_en has priority: with both high, no SRAM read, beat is padded.
- Delay line: RD_LAT-deep shift of {beat, pad, feature_end, pooling_out, sort_out} alongside the SRAM.
- Output stage: total latency input->output = 1 + RD_LAT cycles (3 at default).
  - o_feat_valid = delayed beat.
  - o_feat_data = {DATA_W/8{PAD_VAL}} if delayed pad, else i_buf_rd_data; 0 when not valid.
  - Sideband outputs are the delayed copies. They pulse even when beat=0 (standalone marker).
- No backpressure; one beat accepted per cycle, throughput 1.
- FSM:
  - IDLE -> ACTIVE on start_calculate; clears o_proto_err.
  - ACTIVE -> DRAIN on i_feature_end.
  - DRAIN -> IDLE when all delay-line valid bits and sideband bits are 0. o_done pulses that cycle, i.e. exactly 1 + RD_LAT cycles after the i_feature_end cycle.
- Errors:
  - start_calculate in ACTIVE or DRAIN: ignored, sets o_proto_err.
  - i_rd_en/i_pad_en in IDLE: still processed, sets o_proto_err.
  - Beats arriving in DRAIN: processed; drain completes only once they leave the pipeline.
- Simultaneous start_calculate and i_feature_end in IDLE: go ACTIVE then DRAIN next cycle; the end beat is carried.

Optional Feature:
- Macro FEAT_READ_PERF_CNT_EN.
- With it: adds outputs o_rd_cnt[15:0] (SRAM reads issued) and o_pad_cnt[15:0] (padded beats emitted).
  - Both saturate at 16'hFFFF.
  - Both clear on start_calculate accepted in IDLE and on reset.
- Without it: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared NPU package holds:
  - PARA_MODE_* constants
  - ADDR_W / DATA_W defaults
  - FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, DRAIN=2'd2)
- One natural sub-module, feature_sideband_delay: a parameterised RD_LAT-deep shift register for the 5-bit sideband vector, with an any-valid flag used for drain detection.

Test Plan:
- Read path: start, then i_rd_en with addr 13'h010..13'h013 on 4 consecutive cycles and SRAM model returning addr as data.
  - o_buf_rd_en high 1 cycle later.
  - o_feat_valid high 3 cycles after each input, data 16'h010..13 in order.
- Pad: i_rd_en=1 and i_pad_en=1 at addr 13'h020 -> o_buf_rd_en stays 0; 3 cycles later o_feat_valid=1, o_feat_data=128'h0.
- Drain: i_feature_end on the last of 8 beats -> o_feature_end aligned with beat 8; o_done pulses once, same cycle; state returns to IDLE.
- Sideband only: i_pooling_out=1 with no rd/pad -> o_pooling_out pulse at +3 with o_feat_valid=0.
- Protocol and reset:
  - Second start_calculate in ACTIVE sets o_proto_err, which remains set until the next IDLE start.
  - Reset asserted mid-burst clears all outputs immediately (asynchronously), and no o_done is produced.
- RD_LAT=1 and RD_LAT=4 builds: repeat the read-path test; latency is 2 and 5 cycles respectively.
